// File: rtl/eth_tx_frame_arb.sv
// Two-source, frame-granular round-robin arbiter for an Ethernet header +
// payload AXI stream. A grant covers one whole frame, from the header
// handshake through the payload tlast beat, so payload never interleaves.
// Granted frames are counted per source, and the current grant is exposed.
module eth_tx_frame_arb #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   s0_eth_hdr_valid,
    output logic                   s0_eth_hdr_ready,
    input  logic [47:0]            s0_eth_dest_mac,
    input  logic [47:0]            s0_eth_src_mac,
    input  logic [15:0]            s0_eth_type,
    input  logic [DATA_WIDTH-1:0]  s0_eth_payload_axis_tdata,
    input  logic                   s0_eth_payload_axis_tvalid,
    output logic                   s0_eth_payload_axis_tready,
    input  logic                   s0_eth_payload_axis_tlast,
    input  logic                   s0_eth_payload_axis_tuser,

    input  logic                   s1_eth_hdr_valid,
    output logic                   s1_eth_hdr_ready,
    input  logic [47:0]            s1_eth_dest_mac,
    input  logic [47:0]            s1_eth_src_mac,
    input  logic [15:0]            s1_eth_type,
    input  logic [DATA_WIDTH-1:0]  s1_eth_payload_axis_tdata,
    input  logic                   s1_eth_payload_axis_tvalid,
    output logic                   s1_eth_payload_axis_tready,
    input  logic                   s1_eth_payload_axis_tlast,
    input  logic                   s1_eth_payload_axis_tuser,

    output logic                   m_eth_hdr_valid,
    input  logic                   m_eth_hdr_ready,
    output logic [47:0]            m_eth_dest_mac,
    output logic [47:0]            m_eth_src_mac,
    output logic [15:0]            m_eth_type,
    output logic [DATA_WIDTH-1:0]  m_eth_payload_axis_tdata,
    output logic                   m_eth_payload_axis_tvalid,
    input  logic                   m_eth_payload_axis_tready,
    output logic                   m_eth_payload_axis_tlast,
    output logic                   m_eth_payload_axis_tuser,

    output logic                   grant,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] frame_count0,
    output logic [COUNT_WIDTH-1:0] frame_count1
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t state;
    state_t state_next;
    logic   grant_next;
    logic   last_grant;
    logic   frame_done;

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, round-robin history and per-source frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            frame_count0 <= '0;
            frame_count1 <= '0;
        end else begin
            grant <= grant_next;
            if (frame_done) begin
                last_grant <= grant;
                if (grant) begin
                    frame_count1 <= frame_count1 + COUNT_WIDTH'(1);
                end else begin
                    frame_count0 <= frame_count0 + COUNT_WIDTH'(1);
                end
            end
        end
    end

    // Next-state, arbitration and the combinational header/payload muxes.
    always_comb begin
        state_next                 = state;
        grant_next                 = grant;
        frame_done                 = 1'b0;
        s0_eth_hdr_ready           = 1'b0;
        s1_eth_hdr_ready           = 1'b0;
        s0_eth_payload_axis_tready = 1'b0;
        s1_eth_payload_axis_tready = 1'b0;
        m_eth_hdr_valid            = 1'b0;
        m_eth_payload_axis_tvalid  = 1'b0;
        m_eth_dest_mac             = grant ? s1_eth_dest_mac : s0_eth_dest_mac;
        m_eth_src_mac              = grant ? s1_eth_src_mac : s0_eth_src_mac;
        m_eth_type                 = grant ? s1_eth_type : s0_eth_type;
        m_eth_payload_axis_tdata   = grant ? s1_eth_payload_axis_tdata : s0_eth_payload_axis_tdata;
        m_eth_payload_axis_tlast   = grant ? s1_eth_payload_axis_tlast : s0_eth_payload_axis_tlast;
        m_eth_payload_axis_tuser   = grant ? s1_eth_payload_axis_tuser : s0_eth_payload_axis_tuser;

        unique case (state)
            IDLE: begin
                if (s0_eth_hdr_valid || s1_eth_hdr_valid) begin
                    state_next = HDR;
                    if (s0_eth_hdr_valid && s1_eth_hdr_valid) begin
                        grant_next = ~last_grant;
                    end else begin
                        grant_next = s1_eth_hdr_valid;
                    end
                end
            end
            HDR: begin
                m_eth_hdr_valid = grant ? s1_eth_hdr_valid : s0_eth_hdr_valid;
                if (grant) begin
                    s1_eth_hdr_ready = m_eth_hdr_ready;
                end else begin
                    s0_eth_hdr_ready = m_eth_hdr_ready;
                end
                if (m_eth_hdr_valid && m_eth_hdr_ready) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_eth_payload_axis_tvalid = grant ? s1_eth_payload_axis_tvalid
                                                  : s0_eth_payload_axis_tvalid;
                if (grant) begin
                    s1_eth_payload_axis_tready = m_eth_payload_axis_tready;
                end else begin
                    s0_eth_payload_axis_tready = m_eth_payload_axis_tready;
                end
                if (m_eth_payload_axis_tvalid && m_eth_payload_axis_tready &&
                    m_eth_payload_axis_tlast) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Synchronous reset still silences every handshake in the reset cycle.
        if (rst) begin
            s0_eth_hdr_ready           = 1'b0;
            s1_eth_hdr_ready           = 1'b0;
            s0_eth_payload_axis_tready = 1'b0;
            s1_eth_payload_axis_tready = 1'b0;
            m_eth_hdr_valid            = 1'b0;
            m_eth_payload_axis_tvalid  = 1'b0;
            frame_done                 = 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Self-checking bench for eth_tx_frame_arb: per-source frame drivers, a
// scoreboard of expected headers/beats per source, an expected grant order,
// a table of arbitration scenarios and hand-written corner-case sequences.
`timescale 1ns/1ps
module tb_eth_tx_frame_arb;

    localparam int DW = 8;
    localparam int CW = 8;   // narrow counter so the wrap is reachable quickly

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] ty;
        int unsigned len;
        logic [7:0]  base;
        logic        user;
    } frame_t;

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] ty;
    } hdr_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        logic r0;
        logic r1;
        logic first;
    } vec_t;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic          rst;
    logic [1:0]    s_hv, s_tv, s_tl, s_tu;
    logic [47:0]   s_dm [2];
    logic [47:0]   s_sm [2];
    logic [15:0]   s_ty [2];
    logic [DW-1:0] s_td [2];
    logic          s0_hr, s1_hr, s0_tr, s1_tr;
    logic [1:0]    s_hr, s_tr;
    logic          m_hv, m_tv, m_tl, m_tu;
    logic          m_hr = 1'b1;
    logic          m_tr = 1'b1;
    logic [47:0]   m_dm, m_sm;
    logic [15:0]   m_ty;
    logic [DW-1:0] m_td;
    logic          grant, busy;
    logic [CW-1:0] fc0, fc1;

    assign s_hr = {s1_hr, s0_hr};
    assign s_tr = {s1_tr, s0_tr};

    eth_tx_frame_arb #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .s0_eth_hdr_valid(s_hv[0]), .s0_eth_hdr_ready(s0_hr),
        .s0_eth_dest_mac(s_dm[0]), .s0_eth_src_mac(s_sm[0]), .s0_eth_type(s_ty[0]),
        .s0_eth_payload_axis_tdata(s_td[0]), .s0_eth_payload_axis_tvalid(s_tv[0]),
        .s0_eth_payload_axis_tready(s0_tr), .s0_eth_payload_axis_tlast(s_tl[0]),
        .s0_eth_payload_axis_tuser(s_tu[0]),
        .s1_eth_hdr_valid(s_hv[1]), .s1_eth_hdr_ready(s1_hr),
        .s1_eth_dest_mac(s_dm[1]), .s1_eth_src_mac(s_sm[1]), .s1_eth_type(s_ty[1]),
        .s1_eth_payload_axis_tdata(s_td[1]), .s1_eth_payload_axis_tvalid(s_tv[1]),
        .s1_eth_payload_axis_tready(s1_tr), .s1_eth_payload_axis_tlast(s_tl[1]),
        .s1_eth_payload_axis_tuser(s_tu[1]),
        .m_eth_hdr_valid(m_hv), .m_eth_hdr_ready(m_hr),
        .m_eth_dest_mac(m_dm), .m_eth_src_mac(m_sm), .m_eth_type(m_ty),
        .m_eth_payload_axis_tdata(m_td), .m_eth_payload_axis_tvalid(m_tv),
        .m_eth_payload_axis_tready(m_tr), .m_eth_payload_axis_tlast(m_tl),
        .m_eth_payload_axis_tuser(m_tu),
        .grant(grant), .busy(busy), .frame_count0(fc0), .frame_count1(fc1)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_accept = -1;
    logic        rst_req = 1'b1;
    logic        toggle = 1'b0;
    logic [1:0]  hdr_done = '0;
    int unsigned idx [2];
    frame_t      fq [2][$];
    hdr_t        exp_h [2][$];
    beat_t       exp_b [2][$];
    int          exp_grant [$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    task automatic enq(int s, logic [47:0] d, logic [15:0] ty, int unsigned len,
                       logic [7:0] base, logic user);
        frame_t f;
        hdr_t   h;
        beat_t  b;
        f.dest = d; f.src = 48'h02_00_00_00_00_00 | 48'(s); f.ty = ty;
        f.len = len; f.base = base; f.user = user;
        fq[s].push_back(f);
        h.dest = f.dest; h.src = f.src; h.ty = f.ty;
        exp_h[s].push_back(h);
        for (int unsigned k = 0; k < len; k++) begin
            b.data = base + 8'(k);
            b.last = (k == len - 1);
            b.user = user && b.last;
            exp_b[s].push_back(b);
        end
    endtask

    task automatic clear_sb();
        for (int i = 0; i < 2; i++) begin
            fq[i].delete();
            exp_h[i].delete();
            exp_b[i].delete();
            idx[i] = 0;
        end
        hdr_done = '0;
        exp_grant.delete();
    endtask

    task automatic drive();
        rst  = rst_req;
        m_tr = toggle ? ~m_tr : 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (fq[i].size() != 0) begin
                s_hv[i] = !hdr_done[i];
                s_dm[i] = fq[i][0].dest;
                s_sm[i] = fq[i][0].src;
                s_ty[i] = fq[i][0].ty;
                s_tv[i] = hdr_done[i];
                s_td[i] = fq[i][0].base + 8'(idx[i]);
                s_tl[i] = (idx[i] == fq[i][0].len - 1);
                s_tu[i] = fq[i][0].user && (idx[i] == fq[i][0].len - 1);
            end else begin
                s_hv[i] = 1'b0; s_tv[i] = 1'b0; s_tl[i] = 1'b0; s_tu[i] = 1'b0;
                s_dm[i] = '0; s_sm[i] = '0; s_ty[i] = '0; s_td[i] = '0;
            end
        end
    endtask

    task automatic monitor();
        logic  g;
        hdr_t  h;
        beat_t b;
        if (rst) begin
            check("rst_outputs", {s_hr, s_tr, m_hv, m_tv}, '0);
        end else if (!busy) begin
            check("idle_outputs", {s_hr, s_tr, m_hv, m_tv}, '0);
        end else begin
            g = grant;
            check("nongrant_ready", {s_hr[!g], s_tr[!g]}, '0);
            if (m_hv) check("hdr_phase_tready", s_tr[g], 1'b0);
            if (m_tv) begin
                check("tready_mirror", s_tr[g], m_tr);
                check("payload_phase_hdr_ready", s_hr[g], 1'b0);
            end
            if (m_hv && m_hr) begin
                if (exp_h[g].size() == 0) begin
                    fail("hdr_unexpected");
                end else begin
                    h = exp_h[g].pop_front();
                    check("hdr_dest", m_dm, h.dest);
                    check("hdr_src", m_sm, h.src);
                    check("hdr_type", m_ty, h.ty);
                end
                hdr_done[g] = 1'b1;
                last_accept = cyc;
            end
            if (m_tv && m_tr) begin
                if (exp_b[g].size() == 0 || fq[g].size() == 0) begin
                    fail("beat_unexpected");
                end else begin
                    b = exp_b[g].pop_front();
                    check("beat_data", m_td, b.data);
                    check("beat_last", m_tl, b.last);
                    check("beat_user", m_tu, b.user);
                    if (m_tl) begin
                        if (exp_grant.size() == 0) fail("grant_unexpected");
                        else check("grant_order", g, exp_grant.pop_front());
                        void'(fq[g].pop_front());
                        hdr_done[g] = 1'b0;
                        idx[g] = 0;
                    end else begin
                        idx[g]++;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        monitor();
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(int maxc);
        int n = 0;
        while ((fq[0].size() != 0 || fq[1].size() != 0) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) fail("run_timeout");
        tick();
        tick();
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        int   start;
        int   n;

        vecs[0] = '{r0: 1'b1, r1: 1'b0, first: 1'b0};
        vecs[1] = '{r0: 1'b0, r1: 1'b1, first: 1'b1};
        vecs[2] = '{r0: 1'b1, r1: 1'b1, first: 1'b0};
        vecs[3] = '{r0: 1'b0, r1: 1'b1, first: 1'b1};
        vecs[4] = '{r0: 1'b1, r1: 1'b1, first: 1'b0};
        vecs[5] = '{r0: 1'b1, r1: 1'b0, first: 1'b0};
        vecs[6] = '{r0: 1'b1, r1: 1'b1, first: 1'b1};

        clear_sb();
        rst_req = 1'b1;
        tick();
        tick();
        rst_req = 1'b0;
        tick();
        #2;
        check("reset_busy", busy, 1'b0);
        check("reset_grant", grant, 1'b0);
        check("reset_count0", fc0, '0);
        check("reset_count1", fc1, '0);

        // Single 64-byte frame from source 0.
        enq(0, 48'h07_08_09_0a_0b_0c, 16'h88B5, 64, 8'h00, 1'b1);
        exp_grant.push_back(0);
        start = cyc;
        run(400);
        check("hdr_accept_latency", last_accept - start, 1);
        check("single_count0", fc0, 1);
        check("single_count1", fc1, 0);

        // Both sources keep requesting: strict alternation, history favours s1.
        for (int k = 0; k < 4; k++) begin
            enq(0, 48'h0a_00_00_00_00_00 | 48'(k), 16'h0800, 16, 8'h40 + 8'(16 * k), 1'b0);
            enq(1, 48'h0b_00_00_00_00_00 | 48'(k), 16'h86DD, 16, 8'h80 + 8'(16 * k), 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            exp_grant.push_back(1);
            exp_grant.push_back(0);
        end
        run(600);
        check("alt_count0", fc0, 5);
        check("alt_count1", fc1, 4);

        // Table of arbitration scenarios.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].r0) enq(0, 48'h0c_00_00_00_00_00 | 48'(v), 16'h1000, 3, 8'(v * 8), 1'b1);
            if (vecs[v].r1) enq(1, 48'h0d_00_00_00_00_00 | 48'(v), 16'h2000, 3, 8'h80 + 8'(v * 8), 1'b0);
            exp_grant.push_back(int'(vecs[v].first));
            if (vecs[v].r0 && vecs[v].r1) exp_grant.push_back(int'(!vecs[v].first));
            run(200);
        end
        check("table_count0", fc0, 10);
        check("table_count1", fc1, 9);

        // Downstream tready toggling every cycle.
        toggle = 1'b1;
        enq(0, 48'h0e_00_00_00_00_01, 16'h3000, 12, 8'h10, 1'b0);
        enq(1, 48'h0e_00_00_00_00_02, 16'h3001, 12, 8'hA0, 1'b1);
        exp_grant.push_back(1);
        exp_grant.push_back(0);
        run(300);
        toggle = 1'b0;
        check("toggle_count0", fc0, 11);
        check("toggle_count1", fc1, 10);

        // Reset pulse in the middle of an s0 payload.
        enq(0, 48'h0f_00_00_00_00_00, 16'h4000, 16, 8'h30, 1'b0);
        exp_grant.push_back(0);
        n = 0;
        while (idx[0] < 5 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail("midframe_timeout");
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        clear_sb();
        #2;
        check("abort_busy", busy, 1'b0);
        check("abort_count0", fc0, '0);
        check("abort_count1", fc1, '0);
        check("abort_readies", {s_hr, s_tr, m_hv, m_tv}, '0);
        enq(0, 48'h10_00_00_00_00_00, 16'h5000, 2, 8'h50, 1'b0);
        enq(1, 48'h11_00_00_00_00_00, 16'h5001, 2, 8'h60, 1'b0);
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        run(100);
        check("post_abort_count0", fc0, 1);
        check("post_abort_count1", fc1, 1);

        // Counter wrap on source 0.
        for (int k = 0; k < 254; k++) begin
            enq(0, 48'h12_00_00_00_00_00, 16'h6000, 1, 8'(k), 1'(k));
            exp_grant.push_back(0);
        end
        run(2000);
        check("wrap_count0_max", fc0, 255);
        enq(0, 48'h12_00_00_00_00_ff, 16'h6000, 1, 8'hEE, 1'b0);
        exp_grant.push_back(0);
        run(50);
        check("wrap_count0_zero", fc0, 0);
        check("wrap_count1", fc1, 1);
        check("grant_queue_drained", exp_grant.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
